wb_conmax_grant_ctrl: RTL



---
 rtl/wb_conmax_grant_ctrl_pkg.sv | 19 +
 rtl/wb_conmax_grant_ctrl_if.sv | 27 ++
 rtl/wb_conmax_wdt.sv | 39 +++
 rtl/wb_conmax_grant_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/wb_conmax_grant_ctrl_pkg.sv
// Shared constants for the per-slave grant sequencer: master count, state encodings and
// watchdog defaults.
package wb_conmax_grant_ctrl_pkg;

  localparam int unsigned NumMasters = 8;
  localparam int unsigned SelW       = 3;

  localparam int unsigned DefToW     = 8;
  localparam int unsigned DefToLimit = 255;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StGrant   = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  function automatic logic any_term(logic ack, logic err, logic rty);
    return ack | err | rty;
  endfunction

endpackage

// File: rtl/wb_conmax_grant_ctrl_if.sv
// Bus bundle between one slave's grant sequencer and its masters / master-select logic.
interface wb_conmax_grant_ctrl_if;
  import wb_conmax_grant_ctrl_pkg::*;

  logic [NumMasters-1:0] cyc_i;
  logic [NumMasters-1:0] req_o;
  logic [SelW-1:0]       sel_i;
  logic                  ack_i;
  logic                  err_i;
  logic                  rty_i;
  logic                  gnt_vld_o;
  logic [SelW-1:0]       gnt_sel_o;
  logic                  next_o;
  logic                  to_o;
  logic [NumMasters-1:0] mask_o;

  modport slave (
    input  cyc_i, sel_i, ack_i, err_i, rty_i,
    output req_o, gnt_vld_o, gnt_sel_o, next_o, to_o, mask_o
  );

  modport master (
    output cyc_i, sel_i, ack_i, err_i, rty_i,
    input  req_o, gnt_vld_o, gnt_sel_o, next_o, to_o, mask_o
  );

endinterface

// File: rtl/wb_conmax_wdt.sv
// Saturating watchdog counter; hit flags that the count has reached the limit.
module wb_conmax_wdt #(
  parameter int unsigned TO_W     = 8,
  parameter int unsigned TO_LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr,
  input  logic inc,
  input  logic en,
  output logic hit
);

  localparam logic [TO_W-1:0] Limit = TO_W'(TO_LIMIT);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = en && (cnt_q == Limit);

endmodule

// File: rtl/wb_conmax_grant_ctrl.sv
// Per-slave grant sequencer: masks requests, latches the selected master for a whole
// Wishbone cycle, pulses next on release and times out stalled masters.
module wb_conmax_grant_ctrl
  import wb_conmax_grant_ctrl_pkg::*;
#(
  parameter int unsigned TO_W     = DefToW,
  parameter int unsigned TO_LIMIT = DefToLimit,
  parameter bit          TO_EN    = 1'b1
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  wb_conmax_grant_ctrl_if.slave bus
);

  logic [1:0]            state_q, state_d;
  logic [SelW-1:0]       gnt_sel_q, gnt_sel_d;
  logic [NumMasters-1:0] mask_q, mask_d;
  logic                  gnt_vld_q, next_q, to_q;
  logic [NumMasters-1:0] req;
  logic                  term, own_cyc, timeout;
  logic                  wdt_clr, wdt_inc, wdt_hit;

  assign req     = bus.cyc_i & ~mask_q;
  assign term    = any_term(bus.ack_i, bus.err_i, bus.rty_i);
  assign own_cyc = bus.cyc_i[gnt_sel_q];

  always_comb begin
    state_d   = state_q;
    gnt_sel_d = gnt_sel_q;
    timeout   = 1'b0;
    wdt_clr   = 1'b0;
    wdt_inc   = 1'b0;
    case (state_q)
      StIdle: begin
        // A select that does not point at a live request is ignored.
        if (req[bus.sel_i]) begin
          gnt_sel_d = bus.sel_i;
          wdt_clr   = 1'b1;
          state_d   = StGrant;
        end
      end
      StGrant: begin
        if (!own_cyc) begin
          state_d = StRelease;
        end else if (term) begin
          wdt_clr = 1'b1;
        end else if (wdt_hit) begin
          timeout = 1'b1;
          state_d = StRelease;
        end else begin
          wdt_inc = 1'b1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Lockout lasts until the master drops cyc; a fresh timeout wins over the clear.
  always_comb begin
    mask_d = mask_q & bus.cyc_i;
    if (timeout) begin
      mask_d[gnt_sel_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      gnt_sel_q <= '0;
      mask_q    <= '0;
      gnt_vld_q <= 1'b0;
      next_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_sel_q <= gnt_sel_d;
      mask_q    <= mask_d;
      gnt_vld_q <= (state_d == StGrant);
      next_q    <= (state_d == StRelease);
      to_q      <= timeout;
    end
  end

  wb_conmax_wdt #(
    .TO_W    (TO_W),
    .TO_LIMIT(TO_LIMIT)
  ) u_wdt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr    (wdt_clr),
    .inc    (wdt_inc),
    .en     (TO_EN),
    .hit    (wdt_hit)
  );

  assign bus.req_o     = req;
  assign bus.gnt_vld_o = gnt_vld_q;
  assign bus.gnt_sel_o = gnt_sel_q;
  assign bus.next_o    = next_q;
  assign bus.to_o      = to_q;
  assign bus.mask_o    = mask_q;

endmodule
